// File: rtl/board_io_pkg.sv
// Shared types and defaults for the board I/O frontend: IRQ edge modes,
// reset-sequencer states and the edge qualification helper.
package board_io_pkg;

  typedef enum logic [1:0] {
    IRQ_RISE,
    IRQ_FALL,
    IRQ_BOTH
  } irq_mode_e;

  typedef enum logic {
    HOLD,
    RUN
  } rst_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_RST_HOLD_CYCLES = 1024;

  // True when the transition prev -> cur is an edge the given mode reports.
  function automatic logic edge_hit(irq_mode_e mode, logic prev, logic cur);
    unique case (mode)
      IRQ_RISE: return cur & ~prev;
      IRQ_FALL: return ~cur & prev;
      default:  return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by a debouncer
// that accepts a new level only after it has held for DEBOUNCE_CYCLES cycles.
module io_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values; blocking assignments would collapse the sync chain.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      q_o    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      if (s == q_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        q_o   <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_io_frontend.sv
// Board I/O conditioning: PLL-lock-gated SoC reset sequencer, debounced
// buttons/switches and per-button edge interrupts.
module board_io_frontend
  import board_io_pkg::*;
#(
  parameter int        NUM_BTN         = 5,
  parameter int        NUM_SW          = 16,
  parameter int        SYNC_STAGES     = 2,
  parameter int        DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int        RST_HOLD_CYCLES = DEFAULT_RST_HOLD_CYCLES,
  parameter irq_mode_e IRQ_MODE        = IRQ_RISE
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               pll_locked_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic [NUM_SW-1:0]  sw_i,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_SW-1:0]  sw_o,
  output logic [NUM_BTN-1:0] irq_o,
  output logic               irq_any_o,
  output logic               soc_rst_o
);

  localparam int HCW = $clog2(RST_HOLD_CYCLES + 1);

  rst_state_e             state_q;
  logic [HCW-1:0]         hold_cnt_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic [NUM_BTN-1:0]     btn_q;
  logic [NUM_BTN-1:0]     irq_d;

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    io_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .d_i    (btn_i[i]),
      .q_o    (btn_o[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    io_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .d_i    (sw_i[i]),
      .q_o    (sw_o[i])
    );
  end

  // NOTE: irq_d is fully assigned before the loop so no latch is inferred.
  always_comb begin
    irq_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      irq_d[i] = edge_hit(IRQ_MODE, btn_q[i], btn_o[i]);
    end
  end

  // IRQs are only released while staying in RUN, so they can never coincide
  // with soc_rst_o and edges seen during HOLD are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lock_sync_q <= '0;
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      soc_rst_o   <= 1'b1;
      btn_q       <= '0;
      irq_o       <= '0;
      irq_any_o   <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      btn_q       <= btn_o;
      irq_o       <= '0;
      irq_any_o   <= 1'b0;
      unique case (state_q)
        HOLD: begin
          soc_rst_o <= 1'b1;
          if (!lock_s) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HCW'(RST_HOLD_CYCLES - 1)) begin
            state_q    <= RUN;
            soc_rst_o  <= 1'b0;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q    <= HOLD;
            soc_rst_o  <= 1'b1;
            hold_cnt_q <= '0;
          end else begin
            irq_o     <= irq_d;
            irq_any_o <= |irq_d;
          end
        end
        default: begin
          state_q   <= HOLD;
          soc_rst_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_io_frontend.sv
// Directed bench for board_io_frontend: a rising-edge and a both-edge instance
// share stimulus; expected IRQ vectors are queued and matched by a monitor.
module tb_board_io_frontend;
  import board_io_pkg::*;

  localparam int NB = 5;
  localparam int NS = 16;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          pll_locked_i;
  logic [NB-1:0] btn_i;
  logic [NS-1:0] sw_i;

  logic [NB-1:0] btn_r, irq_r, btn_b, irq_b;
  logic [NS-1:0] sw_r, sw_b;
  logic          any_r, soc_r, any_b, soc_b;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  logic [NB-1:0] q_rise[$];
  logic [NB-1:0] q_both[$];
  logic [NB-1:0] prev_r = '0;
  logic [NB-1:0] prev_b = '0;

  always #5 clk_i = ~clk_i;

  board_io_frontend #(
    .NUM_BTN(NB), .NUM_SW(NS), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .RST_HOLD_CYCLES(8), .IRQ_MODE(IRQ_RISE)
  ) dut_rise (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pll_locked_i(pll_locked_i),
    .btn_i(btn_i), .sw_i(sw_i), .btn_o(btn_r), .sw_o(sw_r),
    .irq_o(irq_r), .irq_any_o(any_r), .soc_rst_o(soc_r)
  );

  board_io_frontend #(
    .NUM_BTN(NB), .NUM_SW(NS), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .RST_HOLD_CYCLES(8), .IRQ_MODE(IRQ_BOTH)
  ) dut_both (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pll_locked_i(pll_locked_i),
    .btn_i(btn_i), .sw_i(sw_i), .btn_o(btn_b), .sw_o(sw_b),
    .irq_o(irq_b), .irq_any_o(any_b), .soc_rst_o(soc_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_irq(input logic [NB-1:0] rise_exp, input logic [NB-1:0] both_exp);
    if (rise_exp != '0) q_rise.push_back(rise_exp);
    if (both_exp != '0) q_both.push_back(both_exp);
  endtask

  // Bounded wait for every queued interrupt to be consumed by the monitor.
  task automatic drain(input string tag);
    for (int i = 0; i < 30 && (q_rise.size() != 0 || q_both.size() != 0); i++) tick();
    check({tag, "_rise_left"}, 32'(q_rise.size()), 32'd0);
    check({tag, "_both_left"}, 32'(q_both.size()), 32'd0);
    repeat (4) tick();
  endtask

  // Scoreboard monitor plus the per-cycle irq properties, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (irq_r !== '0 || any_r !== 1'b0) begin
        if (q_rise.size() == 0) check("rise_unexpected_irq", 32'(irq_r), 32'd0);
        else begin
          check("rise_irq", 32'(irq_r), 32'(q_rise.pop_front()));
          check("rise_irq_any", 32'(any_r), 32'd1);
        end
      end
      if (irq_b !== '0 || any_b !== 1'b0) begin
        if (q_both.size() == 0) check("both_unexpected_irq", 32'(irq_b), 32'd0);
        else begin
          check("both_irq", 32'(irq_b), 32'(q_both.pop_front()));
          check("both_irq_any", 32'(any_b), 32'd1);
        end
      end
      check("rise_gate", 32'(irq_r & {NB{soc_r}}), 32'd0);
      check("both_gate", 32'(irq_b & {NB{soc_b}}), 32'd0);
      check("rise_pulse", 32'(irq_r & prev_r), 32'd0);
      check("both_pulse", 32'(irq_b & prev_b), 32'd0);
      prev_r = irq_r;
      prev_b = irq_b;
    end
  end

  initial begin
    int n;
    rst_n_i      = 1'b0;
    pll_locked_i = 1'b1;
    btn_i        = '0;
    sw_i         = '0;
    repeat (3) tick();

    check("rst_soc", 32'(soc_r), 32'd1);
    check("rst_btn", 32'(btn_r), 32'd0);
    check("rst_sw", 32'(sw_r), 32'd0);
    check("rst_irq", 32'(irq_r), 32'd0);
    check("rst_irq_any", 32'(any_r), 32'd0);
    check("rst_soc_both", 32'(soc_b), 32'd1);

    // 1: reset release with lock held; SoC reset drops on the 10th edge.
    rst_n_i = 1'b1;
    mon_en  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t1_soc", 32'(soc_r), 32'(k < 9));
      check("t1_soc_both", 32'(soc_b), 32'(k < 9));
    end

    // 2: clean step on btn0 appears 6 edges later, irq one cycle after.
    btn_i[0] = 1'b1;
    push_irq(5'b00001, 5'b00001);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t2_btn0", 32'(btn_r[0]), 32'(k == 5));
    end
    drain("t2");

    // 3: 3-cycle pulses on btn1 never reach the terminal count.
    for (int r = 0; r < 5; r++) begin
      btn_i[1] = 1'b1;
      repeat (3) tick();
      btn_i[1] = 1'b0;
      repeat (3) tick();
      check("t3_btn1", 32'(btn_r[1]), 32'd0);
    end
    repeat (10) tick();
    check("t3_btn1_final", 32'(btn_r[1]), 32'd0);

    // 4: one-cycle lock drop re-enters HOLD; deasserts 10 edges after return.
    pll_locked_i = 1'b0;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k == 0) pll_locked_i = 1'b1;
      check("t4_soc", 32'(soc_r), 32'(k >= 2 && k < 10));
    end

    // 5: switches and a button settle during HOLD; the button edge is dropped.
    pll_locked_i = 1'b0;
    sw_i         = 16'hA5C3;
    btn_i[2]     = 1'b1;
    repeat (8) tick();
    check("t5_soc_hold", 32'(soc_r), 32'd1);
    check("t5_sw", 32'(sw_r), 32'hA5C3);
    check("t5_sw_both", 32'(sw_b), 32'hA5C3);
    check("t5_btn2", 32'(btn_r[2]), 32'd1);
    pll_locked_i = 1'b1;
    n = 0;
    while (n < 40 && soc_r === 1'b1) begin
      tick();
      n++;
    end
    check("t5_soc_fall", 32'(soc_r), 32'd0);
    check("t5_hold_len", 32'(n), 32'd10);
    check("t5_sw_after", 32'(sw_r), 32'hA5C3);
    repeat (10) tick();
    check("t5_no_irq_left", 32'(q_rise.size() + q_both.size()), 32'd0);

    // 6: falling btn0 pulses only in BOTH mode; then simultaneous edges.
    btn_i[0] = 1'b0;
    push_irq(5'b00000, 5'b00001);
    drain("t6_fall0");
    btn_i[0] = 1'b1;
    btn_i[4] = 1'b1;
    push_irq(5'b10001, 5'b10001);
    drain("t6_rise04");
    btn_i[0] = 1'b0;
    btn_i[4] = 1'b0;
    btn_i[2] = 1'b0;
    push_irq(5'b00000, 5'b10101);
    drain("t6_fall024");
    check("t6_btn_final", 32'(btn_r), 32'd0);
    check("t6_btn_final_both", 32'(btn_b), 32'd0);
    repeat (10) tick();

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
